// File: rtl/snake_pkg.sv
// snake_pkg: shared game mode encoding and default menu button geometry
package snake_pkg;
  typedef enum logic [2:0] {
    MENU  = 3'd0,
    GAME  = 3'd1,
    PAUSE = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4,
    DRAW  = 3'd5,
    ERROR = 3'd6
  } game_mode;
  localparam int DEF_BTN_X     = 540;
  localparam int DEF_BTN_W     = 200;
  localparam int DEF_BTN_H     = 60;
  localparam int DEF_BTN_Y0    = 300;
  localparam int DEF_BTN_PITCH = 100;
  localparam int DEF_BTN_END_Y = 600;
  function automatic logic is_end(game_mode m);
    return m inside {WIN, LOSE, DRAW};
  endfunction
endpackage

// File: rtl/btn_hit_decoder.sv
// btn_hit_decoder: hit test of a point against a vertical stack of equal rectangles
//   x, y : 12-bit point; hit : point inside some rectangle;
//   idx  : lowest index hit, all-ones when none
module btn_hit_decoder #(
  parameter int N     = 1,
  parameter int X     = 0,
  parameter int W     = 1,
  parameter int H     = 1,
  parameter int Y0    = 0,
  parameter int PITCH = 0,
  parameter int IW    = $clog2(N) + 1
) (
  input  logic [11:0]   x,
  input  logic [11:0]   y,
  output logic          hit,
  output logic [IW-1:0] idx
);
  // 13-bit compares so X+W or top+H past 4095 cannot wrap
  logic [12:0] xw, yw;
  logic in_x;
  assign xw = {1'b0, x};
  assign yw = {1'b0, y};
  assign in_x = xw >= 13'(X) && xw < 13'(X + W);
  // scan high to low so the lowest matching index is left standing
  always_comb begin
    hit = 1'b0;
    idx = '1;
    for (int i = N - 1; i >= 0; i--)
      if (in_x && yw >= 13'(Y0 + i * PITCH) && yw < 13'(Y0 + i * PITCH + H)) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl: menu / game / pause / end-screen mode sequencer
//   in : clk_75, rst (sync, active-high), start_game, won, lost, draw, con_error,
//        pause_req, click_x, click_y, click_e
//   out: mode, local_start (1-cycle pulse), n_players, hover_idx (all-ones = none)
module game_mode_ctrl
  import snake_pkg::*;
#(
  parameter int N_BUTTONS   = 2,
  parameter int BTN_X       = DEF_BTN_X,
  parameter int BTN_W       = DEF_BTN_W,
  parameter int BTN_H       = DEF_BTN_H,
  parameter int BTN_Y0      = DEF_BTN_Y0,
  parameter int BTN_PITCH   = DEF_BTN_PITCH,
  parameter int BTN_END_Y   = DEF_BTN_END_Y,
  parameter int END_TIMEOUT = 750_000_000,
  localparam int NPW = $clog2(N_BUTTONS + 1),
  localparam int HW  = $clog2(N_BUTTONS) + 1
) (
  input  logic           clk_75,
  input  logic           rst,
  input  logic           start_game,
  input  logic           won,
  input  logic           lost,
  input  logic           draw,
  input  logic           con_error,
  input  logic           pause_req,
  input  logic [11:0]    click_x,
  input  logic [11:0]    click_y,
  input  logic           click_e,
  output game_mode       mode,
  output logic           local_start,
  output logic [NPW-1:0] n_players,
  output logic [HW-1:0]  hover_idx
);
  game_mode state_n;
  logic menu_hit, ret_hit, ret_ok, ret_click, start_click, timeout, local_start_n;
  logic [HW-1:0] menu_idx, hover_n;
  logic [0:0] ret_idx;
  logic [NPW-1:0] n_players_n;
  logic [31:0] timer;
  btn_hit_decoder #(
    .N(N_BUTTONS), .X(BTN_X), .W(BTN_W), .H(BTN_H), .Y0(BTN_Y0), .PITCH(BTN_PITCH), .IW(HW)
  ) u_menu (.x(click_x), .y(click_y), .hit(menu_hit), .idx(menu_idx));
  btn_hit_decoder #(
    .N(1), .X(BTN_X), .W(BTN_W), .H(BTN_H), .Y0(BTN_END_Y), .PITCH(0), .IW(1)
  ) u_ret (.x(click_x), .y(click_y), .hit(ret_hit), .idx(ret_idx));
  assign ret_ok      = ret_hit && ret_idx == 1'b0;
  assign ret_click   = click_e && ret_ok;
  assign start_click = mode == MENU && click_e && menu_hit;
  assign timeout     = END_TIMEOUT != 0 && timer == 32'(END_TIMEOUT - 1);
  always_ff @(posedge clk_75) begin
    mode        <= rst ? MENU : state_n;
    timer       <= rst ? '0 : (is_end(state_n) && state_n == mode) ? timer + 1 : '0;
    local_start <= rst ? 1'b0 : local_start_n;
    n_players   <= rst ? NPW'(1) : n_players_n;
    hover_idx   <= rst ? '1 : hover_n;
  end
  always_comb begin
    state_n = mode;
    case (mode)
      MENU:  state_n = (start_click || start_game) ? GAME : MENU;
      GAME:  state_n = con_error ? ERROR : won ? WIN : lost ? LOSE : draw ? DRAW :
                       pause_req ? PAUSE : GAME;
      PAUSE: state_n = con_error ? ERROR : pause_req ? GAME : ret_click ? MENU : PAUSE;
      WIN, LOSE, DRAW: state_n = (ret_click || timeout) ? MENU : mode;
      ERROR: state_n = ret_click ? MENU : ERROR;
      default: state_n = MENU;
    endcase
  end
  // start_click already requires a legal MENU encoding, so illegal modes never pulse
  always_comb begin
    local_start_n = start_click;
    n_players_n   = start_click ? NPW'(32'(menu_idx) + 1) : n_players;
    hover_n       = state_n == MENU ? menu_idx : '1;
  end
endmodule

// File: doc/game_mode_ctrl.md
GAME_MODE_CTRL -- requirements
Module: game_mode_ctrl

Interface
REQ-001 SHALL have parameter N_BUTTONS, default 2, number of stacked menu buttons; pressing button i selects i+1 players.
REQ-002 SHALL have parameter BTN_X/BTN_W/BTN_H, defaults 540/200/60, shared x origin, width and height of every button in pixels.
REQ-003 SHALL have parameter BTN_Y0/BTN_PITCH, defaults 300/100, menu button i top y = BTN_Y0 + i*BTN_PITCH.
REQ-004 SHALL have parameter BTN_END_Y, default 600, y of the single return button shown in WIN/LOSE/DRAW/ERROR/PAUSE.
REQ-005 SHALL have parameter END_TIMEOUT, default 750_000_000, cycles before auto-return to MENU from WIN/LOSE/DRAW; 0 disables.
REQ-006 clk_75  in  1  75 MHz system clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start_game  in  1  remote peer started a game.
REQ-009 won, lost, draw, con_error  in  1 each  level result/error flags from game core and link.
REQ-010 pause_req  in  1  single-cycle pause/resume toggle request.
REQ-011 click_x, click_y  in  12 each  mouse coordinates, valid with click_e.
REQ-012 click_e  in  1  single-cycle click strobe.
REQ-013 mode  out  game_mode  current mode.
REQ-014 local_start  out  1  one-cycle pulse: game started locally.
REQ-015 n_players  out  $clog2(N_BUTTONS+1)  selected player count.
REQ-016 hover_idx  out  $clog2(N_BUTTONS)+1  registered index of menu button under cursor; all-ones when none.

Function
REQ-017 Hit test SHALL use half-open ranges: x in [BTN_X, BTN_X+BTN_W), y in [top, top+BTN_H); lowest index wins on overlap; arithmetic SHALL be 13 bits wide so no wrap.
REQ-018 States SHALL be MENU, GAME, PAUSE, WIN, LOSE, DRAW, ERROR; every transition SHALL be visible on mode one cycle after the qualifying input.
REQ-019 MENU: click_e hitting button i -> GAME, local_start=1 for exactly one cycle, n_players=i+1.
REQ-020 MENU: start_game without a valid click -> GAME, local_start=0, n_players unchanged; a valid click SHALL win over start_game in the same cycle.
REQ-021 GAME: priority con_error > won > lost > draw > pause_req; targets ERROR, WIN, LOSE, DRAW, PAUSE; clicks ignored.
REQ-022 PAUSE: con_error -> ERROR; else pause_req -> GAME; else click on return button -> MENU; won/lost/draw ignored.
REQ-023 WIN/LOSE/DRAW: click on return button -> MENU; else end timer reaching END_TIMEOUT-1 -> MENU.
REQ-024 End timer SHALL clear to 0 on every entry to WIN/LOSE/DRAW, increment each cycle there, and hold 0 elsewhere.
REQ-025 ERROR: only a click on the return button -> MENU; no timeout.
REQ-026 hover_idx SHALL update every cycle from click_x/click_y regardless of click_e, only in MENU; all-ones in other modes.
REQ-027 Illegal mode encoding SHALL go to MENU with local_start=0 the next cycle.

Reset
REQ-028 On rst: mode=MENU, local_start=0, n_players=1, hover_idx=all-ones, end timer=0; rst SHALL override any concurrent input, including mid-GAME and mid-timeout.

Structure
REQ-029 game_mode enum (extended with PAUSE) and default button geometry constants SHALL live in snake_pkg.
REQ-030 Hit decoding SHALL be a sub-module btn_hit_decoder (parameterised rectangle stack, outputs hit and index), instantiated twice: menu stack and return button.

Verification
REQ-031 Reset, click (600,310) in MENU -> GAME next cycle, local_start one pulse, n_players=1.
REQ-032 N_BUTTONS=3, click (600,530) with start_game same cycle -> GAME, n_players=3, local_start=1.
REQ-033 GAME, won=1 and con_error=1 same cycle -> ERROR; click (600,610) -> MENU.
REQ-034 END_TIMEOUT=10, enter WIN, no clicks -> MENU exactly 10 cycles after entry; click (740,610) (x out of range) ignored.
REQ-035 GAME, pause_req -> PAUSE; pause_req -> GAME; pause, rst mid-PAUSE -> MENU, all outputs at reset values.
